// File: rtl/board_renderer.sv
// board_renderer: drives the tile copy block to redraw the 20x15 board, with an
// optional full-screen background first, and translates each pixel the copy
// block writes into absolute screen x/y for the VGA framebuffer adapter.
module board_renderer #(
    parameter int unsigned COLS       = 20,
    parameter int unsigned ROWS       = 15,
    parameter int unsigned TILE_BITS  = 5,
    parameter logic [4:0]  EMPTY_TILE = 5'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        draw_bg,
    input  logic        skip_empty,
    output logic        busy,
    output logic        done,
    output logic [8:0]  map_addr,
    input  logic [4:0]  map_data,
    output logic        copy_go,
    output logic [1:0]  copy_mem_select,
    output logic [4:0]  copy_tile_select,
    input  logic        copy_finished,
    input  logic        copy_write_en,
    input  logic [18:0] copy_offset,
    input  logic [14:0] copy_colour,
    output logic [9:0]  vga_x,
    output logic [8:0]  vga_y,
    output logic [14:0] vga_colour,
    output logic        vga_plot
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_BG_GO,
        S_BG_WAIT,
        S_FETCH,
        S_FETCH_WAIT,
        S_TILE_GO,
        S_TILE_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_skip;
    logic [CW-1:0]  r_col;
    logic [RW-1:0]  r_row;
    logic [8:0]     r_map_addr;
    logic [4:0]     r_tile;
    logic           r_plot;
    logic [9:0]     r_x;
    logic [8:0]     r_y;
    logic [14:0]    r_colour;

    logic           w_last_cell;
    logic           w_in_wait;
    logic [9:0]     w_x;
    logic [8:0]     w_y;

    assign w_last_cell = (r_row == RW'(ROWS - 1)) && (r_col == CW'(COLS - 1));
    assign w_in_wait   = (r_state == S_BG_WAIT) || (r_state == S_TILE_WAIT);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control outputs decoded from the current state
    always_comb begin
        w_next          = r_state;
        busy            = 1'b1;
        done            = 1'b0;
        copy_go         = 1'b0;
        copy_mem_select = 2'b00;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = draw_bg ? S_BG_GO : S_FETCH;
                end
            end
            S_BG_GO: begin
                copy_go         = 1'b1;
                copy_mem_select = 2'b01;
                w_next          = S_BG_WAIT;
            end
            S_BG_WAIT: begin
                copy_mem_select = 2'b01;
                if (copy_finished) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                w_next = (r_skip && (map_data == EMPTY_TILE)) ? S_NEXT : S_TILE_GO;
            end
            S_TILE_GO: begin
                copy_go         = 1'b1;
                copy_mem_select = 2'b11;
                w_next          = S_TILE_WAIT;
            end
            S_TILE_WAIT: begin
                copy_mem_select = 2'b11;
                if (copy_finished) begin
                    w_next = S_NEXT;
                end
            end
            S_NEXT: begin
                w_next = w_last_cell ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Cell walk: raster counters with an incrementing address instead of row*COLS+col
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_skip     <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_map_addr <= '0;
            r_tile     <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_skip     <= skip_empty;
                r_col      <= '0;
                r_row      <= '0;
                r_map_addr <= '0;
            end
            if (r_state == S_FETCH_WAIT) begin
                r_tile <= map_data;
            end
            if ((r_state == S_NEXT) && !w_last_cell) begin
                r_map_addr <= r_map_addr + 9'd1;
                if (r_col == CW'(COLS - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    // Screen coordinate for the pixel the copy block is writing this cycle
    always_comb begin
        if (r_state == S_BG_WAIT) begin
            w_x = copy_offset[9:0];
            w_y = copy_offset[18:10];
        end else begin
            w_x = (10'(r_col) << TILE_BITS) + 10'(copy_offset[TILE_BITS-1:0]);
            w_y = (9'(r_row) << TILE_BITS) + 9'(copy_offset[2*TILE_BITS-1:TILE_BITS]);
        end
    end

    // Registered pixel path; strobes outside a copy are dropped
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_plot   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
        end else begin
            r_plot   <= copy_write_en && w_in_wait;
            r_x      <= w_x;
            r_y      <= w_y;
            r_colour <= copy_colour;
        end
    end

    assign map_addr         = r_map_addr;
    assign copy_tile_select = r_tile;
    assign vga_plot         = r_plot;
    assign vga_x            = r_x;
    assign vga_y            = r_y;
    assign vga_colour       = r_colour;

endmodule

// File: tb/tb_board_renderer.sv
// tb_board_renderer: plays the board RAM and the copy block around board_renderer
// and checks launches, handshake, completion and the screen pixel path.
module tb_board_renderer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        draw_bg;
    logic        skip_empty;
    logic        busy;
    logic        done;
    logic [8:0]  map_addr;
    logic [4:0]  map_data;
    logic        copy_go;
    logic [1:0]  copy_mem_select;
    logic [4:0]  copy_tile_select;
    logic        copy_finished;
    logic        copy_write_en;
    logic [18:0] copy_offset;
    logic [14:0] copy_colour;
    logic [9:0]  vga_x;
    logic [8:0]  vga_y;
    logic [14:0] vga_colour;
    logic        vga_plot;

    int n_vec  = 0;
    int n_err  = 0;
    int go_cnt = 0;

    logic [4:0] mem [512];

    // model of the expected pixel outputs
    logic        exp_plot = 1'b0;
    logic        nxt_plot = 1'b0;
    int          exp_x    = 0;
    int          exp_y    = 0;
    int          nxt_x    = 0;
    int          nxt_y    = 0;
    logic [14:0] exp_col  = '0;

    int obs_x0, obs_y0, obs_x1, obs_y1;
    int tail;

    board_renderer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .draw_bg          (draw_bg),
        .skip_empty       (skip_empty),
        .busy             (busy),
        .done             (done),
        .map_addr         (map_addr),
        .map_data         (map_data),
        .copy_go          (copy_go),
        .copy_mem_select  (copy_mem_select),
        .copy_tile_select (copy_tile_select),
        .copy_finished    (copy_finished),
        .copy_write_en    (copy_write_en),
        .copy_offset      (copy_offset),
        .copy_colour      (copy_colour),
        .vga_x            (vga_x),
        .vga_y            (vga_y),
        .vga_colour       (vga_colour),
        .vga_plot         (vga_plot)
    );

    always #5 clk = ~clk;

    // board map RAM, one-cycle synchronous read
    always @(posedge clk) map_data <= mem[map_addr];

    task automatic chk(input string nm, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // one clock: advance the model at the edge, compare pixel outputs at the falling edge
    task automatic step();
        @(posedge clk);
        if (!reset_n) begin
            exp_plot = 1'b0;
            exp_x    = 0;
            exp_y    = 0;
            exp_col  = '0;
        end else begin
            exp_plot = nxt_plot;
            exp_col  = copy_colour;
            if (nxt_plot) begin
                exp_x = nxt_x;
                exp_y = nxt_y;
            end
        end
        nxt_plot = 1'b0;
        @(negedge clk);
        if (copy_go) go_cnt++;
        chk("vga_plot", vga_plot, exp_plot);
        chk("vga_colour", vga_colour, exp_col);
        if (exp_plot) begin
            chk("vga_x", vga_x, exp_x);
            chk("vga_y", vga_y, exp_y);
        end
    endtask

    // copy block writes one pixel; screen position from the cell's row/col
    task automatic pix(input bit bg, input int addr, input int off, input bit fin);
        copy_write_en = 1'b1;
        copy_finished = fin;
        copy_offset   = 19'(off);
        copy_colour   = 15'($urandom);
        nxt_plot      = 1'b1;
        if (bg) begin
            nxt_x = off % 1024;
            nxt_y = off / 1024;
        end else begin
            nxt_x = (addr % 20) * 32 + off % 32;
            nxt_y = (addr / 20) * 32 + (off / 32) % 32;
        end
        step();
        copy_write_en = 1'b0;
        copy_finished = 1'b0;
    endtask

    task automatic redraw(input bit bg, input bit skip, input int hold, input bit stray,
                          output int tail_o);
        int q_sel[$];
        int q_tile[$];
        int q_addr[$];
        int go0;
        int n;
        tail_o = -1;
        if (bg) begin
            q_sel.push_back(1); q_tile.push_back(0); q_addr.push_back(-1);
        end
        for (int a = 0; a < 300; a++) begin
            if (!(skip && mem[a] == 5'd0)) begin
                q_sel.push_back(3); q_tile.push_back(int'(mem[a])); q_addr.push_back(a);
            end
        end
        go0 = go_cnt;
        draw_bg = bg; skip_empty = skip; start = 1'b1;
        copy_write_en = stray; copy_colour = 15'($urandom);
        step();
        start = 1'b0; draw_bg = !bg; skip_empty = !skip;
        chk("busy_after_start", busy, 1);
        if (stray) begin
            step();
            step();
            copy_write_en = 1'b0;
        end
        for (int i = 0; i < q_sel.size(); i++) begin
            n = 0;
            while (!copy_go && n < 1000) begin step(); n++; end
            if (!copy_go) begin
                chk("go_timeout", 0, 1);
                return;
            end
            chk("mem_select", copy_mem_select, q_sel[i]);
            if (q_sel[i] == 3) begin
                chk("tile_select", copy_tile_select, q_tile[i]);
                chk("map_addr", map_addr, q_addr[i]);
            end
            step();
            if (i == 0 && hold > 0) begin
                for (int h = 0; h < hold; h++) begin
                    start   = (h == hold / 2);
                    draw_bg = (h == hold / 2);
                    chk("hold_go", copy_go, 0);
                    chk("hold_sel", copy_mem_select, q_sel[i]);
                    if (q_sel[i] == 3) chk("hold_tile", copy_tile_select, q_tile[i]);
                    chk("hold_busy", busy, 1);
                    step();
                end
                start = 1'b0; draw_bg = !bg;
            end
            if (q_sel[i] == 1) begin
                pix(1'b1, 0, 0, 1'b0);
                obs_x0 = vga_x; obs_y0 = vga_y;
                pix(1'b1, 0, 479 * 1024 + 639, 1'b1);
            end else begin
                pix(1'b0, q_addr[i], 0, 1'b0);
                obs_x0 = vga_x; obs_y0 = vga_y;
                pix(1'b0, q_addr[i], 1023, 1'b1);
            end
            obs_x1 = vga_x; obs_y1 = vga_y;
        end
        n = 0;
        while (!done && n < 2000) begin step(); n++; end
        chk("done_seen", done, 1);
        tail_o = n;
        step();
        chk("done_width", done, 0);
        chk("busy_after_done", busy, 0);
        chk("go_count", go_cnt - go0, q_sel.size());
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 1'b0; start = 1'b0; draw_bg = 1'b0; skip_empty = 1'b0;
        copy_finished = 1'b0; copy_write_en = 1'b0; copy_offset = '0; copy_colour = '0;
        foreach (mem[i]) mem[i] = '0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_go", copy_go, 0);
        chk("rst_sel", copy_mem_select, 0);
        chk("rst_tile", copy_tile_select, 0);
        chk("rst_addr", map_addr, 0);
        chk("rst_x", vga_x, 0);
        chk("rst_y", vga_y, 0);
        reset_n = 1'b1;
        step();

        // stray strobes while idle
        copy_write_en = 1'b1; copy_offset = 19'd5; copy_colour = 15'h1234;
        repeat (3) step();
        copy_write_en = 1'b0;

        // background only
        redraw(1'b1, 1'b1, 0, 1'b0, tail);
        chk("bg_x_first", obs_x0, 0);
        chk("bg_y_first", obs_y0, 0);
        chk("bg_x_last", obs_x1, 639);
        chk("bg_y_last", obs_y1, 479);
        chk("bg_tail_cycles", tail, 900);

        // single tile at row 2 col 3, with stray strobes around FETCH
        mem[43] = 5'd5;
        redraw(1'b0, 1'b1, 0, 1'b1, tail);
        chk("tile_x0", obs_x0, 96);
        chk("tile_y0", obs_y0, 64);
        chk("tile_x1", obs_x1, 127);
        chk("tile_y1", obs_y1, 95);

        // stalled copy, start ignored mid-run
        foreach (mem[i]) mem[i] = '0;
        mem[0] = 5'd7; mem[299] = 5'd9;
        redraw(1'b0, 1'b1, 2000, 1'b0, tail);
        chk("hs_last_x", obs_x1, 639);
        chk("hs_last_y", obs_y1, 479);

        // full sweep, every cell launched
        for (int a = 0; a < 300; a++) mem[a] = 5'($urandom_range(0, 31));
        mem[0] = 5'd0;
        redraw(1'b0, 1'b0, 0, 1'b0, tail);
        chk("sweep_last_x", obs_x1, 639);
        chk("sweep_last_y", obs_y1, 479);

        // reset during TILE_WAIT
        foreach (mem[i]) mem[i] = '0;
        mem[45] = 5'd4;
        draw_bg = 1'b0; skip_empty = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!copy_go && n < 1000) begin step(); n++; end
        chk("rst_go_seen", copy_go, 1);
        step();
        pix(1'b0, 45, 33, 1'b0);
        reset_n = 1'b0; copy_finished = 1'b1; copy_write_en = 1'b1;
        step();
        reset_n = 1'b1; copy_finished = 1'b0; copy_write_en = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_go", copy_go, 0);
        chk("mid_rst_sel", copy_mem_select, 0);
        chk("mid_rst_tile", copy_tile_select, 0);
        chk("mid_rst_addr", map_addr, 0);
        chk("mid_rst_x", vga_x, 0);
        chk("mid_rst_y", vga_y, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_go", copy_go, 0);
        end
        mem[0] = 5'd3;
        redraw(1'b0, 1'b1, 0, 1'b0, tail);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
